// File: rtl/dotl_monitor_if.sv
// Observation bus between the dice/traffic-light block and its monitor.
// The master side drives the sampled dotl signals; the slave side is the
// monitor, which returns lock and error status.
interface dotl_monitor_if #(
    parameter int ERR_W = 8
);
    logic             sel;
    logic             button;
    logic [2:0]       result;
    logic             locked;
    logic             err;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;

    modport master (
        output sel, button, result,
        input  locked, err, err_sticky, err_count
    );

    modport slave (
        input  sel, button, result,
        output locked, err, err_sticky, err_count
    );
endinterface

// File: rtl/dotl_monitor.sv
// Passive checker for the dotl result bus. Tracks the expected next value
// for dice and traffic-light modes and counts illegal encodings/transitions.
// Optional statistics counters are enabled with DOTL_MON_STATS_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// SYNC  | no reference yet; only legality of result is checked
// TRACK | locked; result is compared against the predicted value
module dotl_monitor #(
    parameter int ERR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    dotl_monitor_if.slave bus
`ifdef DOTL_MON_STATS_EN
    ,
    output logic [15:0] tl_cycles,
    output logic [15:0] dice_wraps
`endif
);
    typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_result_q;
    logic             r_sel_q;
    logic             r_button_q;
    logic             r_err;
    logic             r_err_sticky;
    logic [ERR_W-1:0] r_err_count;

    logic             w_mode_chg;
    logic             w_legal;
    logic             w_checking;
    logic             w_viol;
    logic [2:0]       w_expect;

    function automatic logic is_legal(input logic mode, input logic [2:0] v);
        if (!mode) return (v != 3'd0) && (v != 3'd7);
        return (v == 3'b100) || (v == 3'b110) || (v == 3'b001) || (v == 3'b010);
    endfunction

    function automatic logic [2:0] predict(input logic mode, input logic btn,
                                           input logic [2:0] q);
        if (!mode) begin
            if (!btn)      return q;
            if (q == 3'd6) return 3'd1;
            return q + 3'd1;
        end
        case (q)
            3'b100:  return 3'b110;
            3'b110:  return 3'b001;
            3'b001:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // State and history registers, plus error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SYNC;
            r_result_q   <= 3'd0;
            r_sel_q      <= 1'b0;
            r_button_q   <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_next;
            r_result_q   <= bus.result;
            r_sel_q      <= bus.sel;
            r_button_q   <= bus.button;
            r_err        <= w_viol;
            r_err_sticky <= r_err_sticky | w_viol;
            if (w_viol && (r_err_count != '1))
                r_err_count <= r_err_count + ERR_W'(1);
        end
    end

    // Next state: a mode change or SYNC only checks legality; TRACK also
    // compares against the prediction. Either way a legal value (re)locks.
    always_comb begin
        w_mode_chg = (bus.sel != r_sel_q);
        w_legal    = is_legal(bus.sel, bus.result);
        w_expect   = predict(r_sel_q, r_button_q, r_result_q);
        w_checking = (r_state == TRACK) && !w_mode_chg;
        w_viol     = w_checking ? (bus.result != w_expect) : !w_legal;
        w_next     = w_legal ? TRACK : SYNC;
    end

    // Status outputs.
    always_comb begin
        bus.locked     = (r_state == TRACK);
        bus.err        = r_err;
        bus.err_sticky = r_err_sticky;
        bus.err_count  = r_err_count;
    end

`ifdef DOTL_MON_STATS_EN
    logic [15:0] r_tl_cycles;
    logic [15:0] r_dice_wraps;
    logic        w_tl_step;
    logic        w_dice_wrap;

    // Completed light cycles (amber -> red) and dice wraps (6 -> 1).
    always_comb begin
        w_tl_step   = w_checking && r_sel_q && (r_result_q == 3'b010) &&
                      (bus.result == 3'b100);
        w_dice_wrap = w_checking && !r_sel_q && r_button_q &&
                      (r_result_q == 3'd6) && (bus.result == 3'd1);
    end

    // Statistics counters wrap freely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tl_cycles  <= 16'd0;
            r_dice_wraps <= 16'd0;
        end else begin
            if (w_tl_step)   r_tl_cycles  <= r_tl_cycles + 16'd1;
            if (w_dice_wrap) r_dice_wraps <= r_dice_wraps + 16'd1;
        end
    end

    assign tl_cycles  = r_tl_cycles;
    assign dice_wraps = r_dice_wraps;
`endif
endmodule

// File: doc/dotl_monitor.md
# dotl_monitor

Passive checker on the far end of the dice/traffic-light `result` bus. It samples `sel`, `button` and `result[2:0]` every clock. It predicts the next legal value for the selected mode and flags every illegal encoding or illegal transition. It sits beside `dotl` in the top level and the bench, drives nothing back into it, and exposes a sticky error flag plus a saturating error count for LEDs or a bench.

## Interface
- `ERR_W`, default 8: width of `err_count`.
- `clk` input 1: sole clock; everything is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sel` input 1: mode as driven to `dotl`.
  - 0 = dice.
  - 1 = traffic lights.
- `button` input 1: dice roll enable as driven to `dotl`.
- `result` input 3: output of `dotl` under observation.
- `locked` output 1: monitor has a valid reference value and is checking transitions.
- `err` output 1: one-cycle pulse per detected violation.
- `err_sticky` output 1: set by any violation; cleared only by `rst`.
- `err_count` output ERR_W: number of violations, saturating at all-ones.

## Operation
- **Legal encodings**
  - Dice: 1 to 6. Values 0 and 7 are illegal.
  - Traffic lights: red 100, red+amber 110, green 001, amber 010. All other values are illegal.
- **Transition rules.** The monitor registers `result_q`, `button_q` and `sel_q` each cycle.
  - Dice, `button_q`=1: the expected value is `result_q`+1, with 6 wrapping to 1.
  - Dice, `button_q`=0: the expected value is `result_q`, i.e. hold.
  - Traffic lights: the value advances every cycle regardless of `button`: 100 → 110 → 001 → 010 → 100.
- **States**
  - SYNC
    - `locked`=0.
    - If `result` is legal for `sel`, capture it and go to TRACK.
    - If it is illegal, raise a violation and stay in SYNC.
  - TRACK
    - `locked`=1.
    - Each cycle, compare `result` against the value predicted from `result_q`, `button_q` and `sel_q`.
    - A mismatch raises a violation. The actual `result` becomes the new reference if it is legal; otherwise go to SYNC.
- **Mode change.** When `sel` differs from `sel_q`, no transition check is made.
  - The state goes to SYNC handling for that cycle: legality check only, then re-lock.
  - Reason: both `dotl` sub-blocks run freely, so the first value after a switch is unpredictable.
- **Violation effects**, all in the same cycle:
  - `err` pulses.
  - `err_sticky` is set.
  - `err_count` increments unless it is already all-ones; it then holds.

## Timing
- **Reset.** `rst` sampled high forces:
  - state SYNC, `locked`=0, `err`=0, `err_sticky`=0, `err_count`=0.
  - `result_q`=0, `sel_q`=0, `button_q`=0.
  - While `rst` is high, `result` is ignored. Reset asserted mid-TRACK discards all history at that edge.
- **Lock latency.** The first edge after `rst` deasserts that samples a legal `result` sets `locked`. `locked` is visible in the following cycle.
- **Error latency.** `err`, `err_sticky` and `err_count` update on the same edge that samples the offending `result`. They are visible one cycle after the bad value first appears on the bus. `err` stays high for exactly one cycle per violating sample.
- **Back-to-back violations.** Consecutive violating samples give consecutive `err` pulses, and the count increments on each.
- **Simultaneous events.** Priority is `rst` > `sel` change > TRACK check.
- **Button sampling.** `button` is sampled at the same edge as `dotl`. The `button` value held before the edge governs the transition seen after it.

## Configuration
- `DOTL_MON_STATS_EN` defined:
  - Adds output `tl_cycles` [15:0], which increments each time TRACK in traffic mode checks a legal 010 → 100 transition.
  - Adds output `dice_wraps` [15:0], which increments on each legal 6 → 1 dice transition.
  - Both counters wrap modulo 2^16 and reset to 0.
- `DOTL_MON_STATS_EN` not defined: both ports and their logic are absent. All other behaviour is identical.

## Test plan
- **Reset, then lock.** `rst`=1 for 2 cycles, then `sel`=0, `result`=3 → `locked`=1 next cycle, `err`=0, `err_count`=0.
- **Dice roll with hold and wrap.** `sel`=0, `button`=1, `result` 5,6,1,2, then `button`=0 with `result` held at 2 → no `err`. With stats enabled, `dice_wraps`=1.
- **Traffic lights, full cycle.** `sel`=1, `result` 100,110,001,010,100 → no `err`. With stats enabled, `tl_cycles`=1.
- **Illegal transitions.**
  - `sel`=1: `result` goes 110 → 010 → single `err` pulse, `err_sticky`=1, `err_count`=1.
  - Then `sel`=0 with `result`=7 → second pulse, `err_count`=2, `locked`=0.
- **Mode switch mid-sequence.** Dice is locked at 4; `sel` goes to 1 with `result`=001 → no `err`. Tracking continues with 010 expected next.
- **Saturation and mid-run reset.**
  - `ERR_W`=2 with 5 violating samples → `err_count` holds at 3.
  - Then `rst` pulses → all outputs 0 and `locked`=0 on the next cycle.
